// File: rtl/i2c_target_pkg.sv
// Shared types and constants for the I2C target controller.
package i2c_target_pkg;

  localparam int I2C_BYTE_W = 8;
  localparam int I2C_ADDR_W = 7;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_RX_BYTE,
    ST_RX_ACK,
    ST_TX_BYTE,
    ST_TX_ACK,
    ST_WAIT_STOP
  } i2c_tgt_state_e;

endpackage

// File: rtl/i2c_sync_filter.sv
// Pad synchronizer followed by a stability filter; emits the filtered level
// plus one-cycle rise/fall pulses aligned with the filtered level change.
module i2c_sync_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic in_i,
  output logic filt_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_LEN - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_filt;
  logic                   r_rise;
  logic                   r_fall;
  logic                   w_sync;

  assign w_sync = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], in_i};
    end
  end

  // The filtered level only follows the input after FILTER_LEN consecutive
  // cycles of disagreement; any shorter excursion restarts the count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt  <= '0;
      r_filt <= 1'b1;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (w_sync == r_filt) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_MAX) begin
        r_cnt  <= '0;
        r_filt <= w_sync;
        r_rise <= w_sync;
        r_fall <= ~w_sync;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign filt_o = r_filt;
  assign rise_o = r_rise;
  assign fall_o = r_fall;

endmodule

// File: rtl/i2c_target_ctrl.sv
// I2C target: START/STOP detection, 7-bit address match, write bytes out as
// valid pulses, read bytes fetched through a request/data pair.
module i2c_target_ctrl
  import i2c_target_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe_o,
  input  logic [6:0] own_addr_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       tx_req_o,
  input  logic [7:0] tx_data_i,
  output logic       start_o,
  output logic       stop_o,
  output logic       busy_o,
  output logic [2:0] dbg_state_o
);

  logic w_scl, w_scl_rise, w_scl_fall;
  logic w_sda, w_sda_rise, w_sda_fall;
  logic w_start, w_stop;

  i2c_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_scl (
    .clk_i(clk_i), .rst_ni(rst_ni), .in_i(scl_i),
    .filt_o(w_scl), .rise_o(w_scl_rise), .fall_o(w_scl_fall)
  );

  i2c_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_sda (
    .clk_i(clk_i), .rst_ni(rst_ni), .in_i(sda_i),
    .filt_o(w_sda), .rise_o(w_sda_rise), .fall_o(w_sda_fall)
  );

  assign w_start = w_sda_fall & w_scl;
  assign w_stop  = w_sda_rise & w_scl;

  i2c_tgt_state_e          r_state, w_state_nxt;
  logic [I2C_BYTE_W-1:0]   r_shreg, w_shreg_nxt;
  logic [2:0]              r_bitcnt, w_bitcnt_nxt;
  logic                    r_done, w_done_nxt;
  logic                    r_rw, w_rw_nxt;
  logic                    r_sda_oe, w_sda_oe_nxt;
  logic [I2C_BYTE_W-1:0]   r_rx_data, w_rx_data_nxt;
  logic                    r_rx_valid, w_rx_valid_nxt;
  logic                    r_tx_req, w_tx_req_nxt;
  logic                    r_start, w_start_nxt;
  logic                    r_stop, w_stop_nxt;
  logic                    r_busy, w_busy_nxt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= ST_IDLE;
      r_shreg    <= '0;
      r_bitcnt   <= '0;
      r_done     <= 1'b0;
      r_rw       <= 1'b0;
      r_sda_oe   <= 1'b0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_tx_req   <= 1'b0;
      r_start    <= 1'b0;
      r_stop     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_shreg    <= w_shreg_nxt;
      r_bitcnt   <= w_bitcnt_nxt;
      r_done     <= w_done_nxt;
      r_rw       <= w_rw_nxt;
      r_sda_oe   <= w_sda_oe_nxt;
      r_rx_data  <= w_rx_data_nxt;
      r_rx_valid <= w_rx_valid_nxt;
      r_tx_req   <= w_tx_req_nxt;
      r_start    <= w_start_nxt;
      r_stop     <= w_stop_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  // Bus conditions take priority over any SCL edge seen in the same cycle.
  // In TX_ACK the done flag records that the master acknowledged.
  always_comb begin
    w_state_nxt    = r_state;
    w_shreg_nxt    = r_shreg;
    w_bitcnt_nxt   = r_bitcnt;
    w_done_nxt     = r_done;
    w_rw_nxt       = r_rw;
    w_sda_oe_nxt   = r_sda_oe;
    w_rx_data_nxt  = r_rx_data;
    w_rx_valid_nxt = 1'b0;
    w_tx_req_nxt   = 1'b0;
    w_start_nxt    = 1'b0;
    w_stop_nxt     = 1'b0;
    w_busy_nxt     = r_busy;
    if (w_start) begin
      w_state_nxt  = ST_ADDR;
      w_bitcnt_nxt = '0;
      w_done_nxt   = 1'b0;
      w_sda_oe_nxt = 1'b0;
      w_start_nxt  = 1'b1;
      w_busy_nxt   = 1'b1;
    end else if (w_stop) begin
      w_state_nxt  = ST_IDLE;
      w_bitcnt_nxt = '0;
      w_done_nxt   = 1'b0;
      w_sda_oe_nxt = 1'b0;
      w_stop_nxt   = 1'b1;
      w_busy_nxt   = 1'b0;
    end else begin
      case (r_state)
        ST_ADDR, ST_RX_BYTE: begin
          if (w_scl_rise && !r_done) begin
            w_shreg_nxt = {r_shreg[I2C_BYTE_W-2:0], w_sda};
            if (r_bitcnt == 3'd7) begin
              w_done_nxt = 1'b1;
              if (r_state == ST_RX_BYTE) begin
                w_rx_data_nxt  = {r_shreg[I2C_BYTE_W-2:0], w_sda};
                w_rx_valid_nxt = 1'b1;
              end
            end else begin
              w_bitcnt_nxt = r_bitcnt + 3'd1;
            end
          end else if (w_scl_fall && r_done) begin
            if (r_state == ST_RX_BYTE) begin
              w_state_nxt  = ST_RX_ACK;
              w_sda_oe_nxt = 1'b1;
            end else if (r_shreg[7:1] == own_addr_i) begin
              w_state_nxt  = ST_ADDR_ACK;
              w_sda_oe_nxt = 1'b1;
              w_rw_nxt     = r_shreg[0];
              w_tx_req_nxt = r_shreg[0];
            end else begin
              w_state_nxt  = ST_WAIT_STOP;
              w_sda_oe_nxt = 1'b0;
            end
          end
        end
        ST_ADDR_ACK, ST_RX_ACK: begin
          if (w_scl_fall) begin
            w_bitcnt_nxt = '0;
            w_done_nxt   = 1'b0;
            if (r_state == ST_ADDR_ACK && r_rw) begin
              w_state_nxt  = ST_TX_BYTE;
              w_shreg_nxt  = tx_data_i;
              w_sda_oe_nxt = ~tx_data_i[7];
            end else begin
              w_state_nxt  = ST_RX_BYTE;
              w_sda_oe_nxt = 1'b0;
            end
          end
        end
        ST_TX_BYTE: begin
          if (w_scl_rise && !r_done) begin
            w_shreg_nxt = {r_shreg[I2C_BYTE_W-2:0], 1'b0};
            if (r_bitcnt == 3'd7) w_done_nxt = 1'b1;
            else                  w_bitcnt_nxt = r_bitcnt + 3'd1;
          end else if (w_scl_fall) begin
            if (r_done) begin
              w_state_nxt  = ST_TX_ACK;
              w_sda_oe_nxt = 1'b0;
              w_done_nxt   = 1'b0;
            end else begin
              w_sda_oe_nxt = ~r_shreg[7];
            end
          end
        end
        ST_TX_ACK: begin
          if (w_scl_rise) begin
            if (w_sda == I2C_ACK) begin
              w_done_nxt   = 1'b1;
              w_tx_req_nxt = 1'b1;
            end else begin
              w_state_nxt = ST_WAIT_STOP;
            end
          end else if (w_scl_fall && r_done) begin
            w_state_nxt  = ST_TX_BYTE;
            w_shreg_nxt  = tx_data_i;
            w_sda_oe_nxt = ~tx_data_i[7];
            w_bitcnt_nxt = '0;
            w_done_nxt   = 1'b0;
          end
        end
        ST_WAIT_STOP: w_sda_oe_nxt = 1'b0;
        default: ;
      endcase
    end
  end

  assign sda_oe_o    = r_sda_oe;
  assign rx_data_o   = r_rx_data;
  assign rx_valid_o  = r_rx_valid;
  assign tx_req_o    = r_tx_req;
  assign start_o     = r_start;
  assign stop_o      = r_stop;
  assign busy_o      = r_busy;
  assign dbg_state_o = r_state;

endmodule
